// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, completion codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction and extension for loads, and
// legality/alignment classification of an incoming request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    output logic        illegal,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        be       = '0;
        wdata    = '0;
        if (is_load && is_store)
            illegal = 1'b1;
        else if (is_store)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else if (is_load)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

        case (funct3)
            F3_H, F3_HU: misalign = off[0];
            F3_W:        misalign = |off;
            default:     misalign = 1'b0;
        endcase

        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be    = 4'b0001 << off;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = off[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                F3_W: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
                default: ;
            endcase
        end else begin
            be = 4'b1111;
        end
    end

    always_comb begin
        case (ld_funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, ld_byte};
            F3_HU:   load_data = {16'd0, ld_half};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: request/ready data-memory transaction with timeout, stall output
// and a registered, extended load result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       f3_q, f3_nx;
    logic [1:0]       off_q, off_nx;
    logic             done_nx, mem_we_nx;
    logic [1:0]       err_nx;
    logic [31:0]      load_data_nx, mem_addr_nx, mem_wdata_nx;
    logic [3:0]       mem_be_nx;
    logic             illegal, misalign;
    logic [3:0]       be;
    logic [31:0]      wdata, ld_ext;

    // Request and stall follow the state register directly so reset drops them at once.
    assign busy    = (state == S_REQ);
    assign mem_req = (state == S_REQ);

    lsu_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .off        (addr[1:0]),
        .store_data (store_data),
        .illegal    (illegal),
        .misalign   (misalign),
        .be         (be),
        .wdata      (wdata),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (mem_rdata),
        .load_data  (ld_ext)
    );

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        f3_nx        = f3_q;
        off_nx       = off_q;
        done_nx      = 1'b0;
        err_nx       = err;
        load_data_nx = load_data;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        mem_be_nx    = mem_be;
        case (state)
            S_IDLE: begin
                if (start && (is_load || is_store)) begin
                    if (illegal || misalign) begin
                        done_nx      = 1'b1;
                        err_nx       = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        load_data_nx = '0;
                    end else begin
                        state_nx     = S_REQ;
                        cnt_nx       = '0;
                        f3_nx        = funct3;
                        off_nx       = addr[1:0];
                        mem_we_nx    = is_store;
                        mem_addr_nx  = {addr[31:2], 2'b00};
                        mem_be_nx    = be;
                        mem_wdata_nx = wdata;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_nx     = S_IDLE;
                    cnt_nx       = '0;
                    done_nx      = 1'b1;
                    err_nx       = ERR_OK;
                    load_data_nx = mem_we ? '0 : ld_ext;
                end else if (cnt == CNT_LAST) begin
                    state_nx     = S_IDLE;
                    cnt_nx       = '0;
                    done_nx      = 1'b1;
                    err_nx       = ERR_TIMEOUT;
                    load_data_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            done      <= 1'b0;
            err       <= '0;
            load_data <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            f3_q      <= f3_nx;
            off_q     <= off_nx;
            done      <= done_nx;
            err       <= err_nx;
            load_data <= load_data_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            mem_be    <= mem_be_nx;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a width/offset arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_load, is_store, mem_ready;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [1:0]  err;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // kind: 0 ignored, 1 illegal, 2 misaligned, 3 memory access
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                  output int kind, output logic [3:0] exp_be,
                                  output logic [31:0] exp_wd, output logic [31:0] exp_ld);
        int sz, off;
        bit uns;
        longint v;
        off = int'(a % 4);
        uns = 0;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin sz = 1; uns = 1; end
            3'd5: begin sz = 2; uns = 1; end
            default: sz = 0;
        endcase
        kind = 3; exp_be = '0; exp_wd = '0; exp_ld = '0;
        if (!ld && !st) kind = 0;
        else if ((ld && st) || sz == 0 || (st && uns)) kind = 1;
        else if (off % sz != 0) kind = 2;
        else if (st) begin
            exp_be = 4'(((1 << sz) - 1) << off);
            if (sz == 4) exp_wd = sd;
            else if (sz == 2) exp_wd = {16'd0, sd[15:0]} * 32'h0001_0001;
            else exp_wd = {24'd0, sd[7:0]} * 32'h0101_0101;
        end else begin
            exp_be = 4'hF;
            v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
            if (!uns && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            exp_ld = v[31:0];
        end
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int wait_n, output logic [31:0] got_ld);
        int kind;
        logic [3:0] e_be;
        logic [31:0] e_wd, e_ld;
        model(ld, st, f3, a, sd, rd, kind, e_be, e_wd, e_ld);
        start = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 0;
        if (kind == 0) begin
            n_checks++;
            if ({done, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ignored_start: done,req=%b want 00", {done, mem_req}); end
        end else if (kind == 1 || kind == 2) begin
            n_checks++;
            if ({done, mem_req, busy} !== 3'b100) begin n_fail++; $display("FAIL err_done: done,req,busy=%b want 100", {done, mem_req, busy}); end
            n_checks++;
            if (err !== (kind == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL err_code: err=%b kind=%0d", err, kind); end
            n_checks++;
            if (load_data !== 32'd0) begin n_fail++; $display("FAIL err_load_data: got %h want 0", load_data); end
        end else begin
            n_checks++;
            if ({mem_req, busy, done} !== 3'b110) begin n_fail++; $display("FAIL req_issue: req,busy,done=%b want 110", {mem_req, busy, done}); end
            n_checks++;
            if (mem_addr !== ((a >> 2) << 2) || mem_we !== st || mem_be !== e_be) begin
                n_fail++; $display("FAIL req_fields: addr=%h we=%b be=%b want %h %b %b", mem_addr, mem_we, mem_be, (a >> 2) << 2, st, e_be);
            end
            if (st) begin
                n_checks++;
                if (mem_wdata !== e_wd) begin n_fail++; $display("FAIL store_wdata: got %h want %h", mem_wdata, e_wd); end
            end
            for (int w = 0; w < wait_n; w++) begin
                start = 1; addr = $urandom; mem_rdata = $urandom;
                @(posedge clk); #1;
                start = 0;
                n_checks++;
                if (mem_req !== 1'b1 || done !== 1'b0 || mem_addr !== ((a >> 2) << 2) || mem_be !== e_be) begin
                    n_fail++; $display("FAIL req_hold: req=%b done=%b addr=%h be=%b", mem_req, done, mem_addr, mem_be);
                end
            end
            mem_ready = 1; mem_rdata = rd;
            @(posedge clk); #1;
            mem_ready = 0; mem_rdata = $urandom;
            n_checks++;
            if ({done, busy, mem_req} !== 3'b100 || err !== 2'b00) begin
                n_fail++; $display("FAIL completion: done,busy,req=%b err=%b want 100 00", {done, busy, mem_req}, err);
            end
            n_checks++;
            if (load_data !== (st ? 32'd0 : e_ld)) begin n_fail++; $display("FAIL load_data: got %h want %h", load_data, st ? 32'd0 : e_ld); end
        end
        got_ld = load_data;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; is_load = 0; is_store = 0; funct3 = '0; addr = '0;
        store_data = '0; mem_ready = 0; mem_rdata = '0;
        #3;
        n_checks++;
        if ({busy, done, mem_req, mem_we, err, mem_be} !== 10'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, mem_req, mem_we, err, mem_be});
        end
        n_checks++;
        if ({load_data, mem_addr, mem_wdata} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {load_data, mem_addr, mem_wdata});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_directed();
        logic [31:0] g;
        do_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, g);
        do_txn(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF7F, 0, g);
        n_checks++;
        if (g !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_value: got %h want ffffff80", g); end
        do_txn(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_FF7F, 1, g);
        n_checks++;
        if (g !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_value: got %h want 00000080", g); end
        do_txn(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2, g);
        do_txn(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, g);
        do_txn(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, g);
        do_txn(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, g);
        do_txn(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0, g);
        n_checks++;
        if (g !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_value: got %h want 00008001", g); end
    endtask

    task automatic test_idle_ignore();
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 0;
        n_checks++;
        if ({done, mem_req, busy} !== 3'b000) begin n_fail++; $display("FAIL idle_ready: done,req,busy=%b want 000", {done, mem_req, busy}); end
    endtask

    task automatic test_timeout_back_to_back();
        int n;
        logic [31:0] g;
        start = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40; mem_ready = 0;
        @(posedge clk); #1;
        start = 0;
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", n); end
        n_checks++;
        if ({done, busy} !== 2'b10 || err !== 2'b11 || load_data !== 32'd0) begin
            n_fail++; $display("FAIL timeout_done: done,busy=%b err=%b ld=%h", {done, busy}, err, load_data);
        end
        do_txn(1, 0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 0, g);
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [31:0] g;
        start = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h80;
        @(posedge clk); #1;
        start = 0;
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_up: got %b want 1", mem_req); end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_drop: req,busy=%b want 00", {mem_req, busy}); end
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d done pulses want 0", seen); end
        do_txn(1, 0, 3'b010, 32'h84, 32'h0, 32'h1357_9BDF, 1, g);
    endtask

    task automatic test_random();
        logic [31:0] g;
        logic ld, st;
        logic [2:0] f3;
        int r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 15);
            ld = (r == 1) || (r >= 2 && r < 9);
            st = (r == 1) || (r >= 9);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            do_txn(ld, st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 2), g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_idle_ignore();
        test_timeout_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result as the effective byte address, plus the rs2 value as store data.
- Runs a request/ready transaction to the data memory, with byte-lane steering and load sign/zero extension.
- Provides a stall signal to the core and returns a registered load value to writeback.

Parameters:
- TIMEOUT, 255, max cycles mem_req may wait for mem_ready before aborting (1..1023).
- CNT_W, 10, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request from execute; sampled only when busy=0.
- is_load  input  1  operation is a load.
- is_store  input  1  operation is a store.
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- addr  input  32  effective byte address (ALU result).
- store_data  input  32  rs2 value, right-aligned.
- busy  output  1  stall core; high while a transaction is outstanding.
- done  output  1  one-cycle completion pulse.
- load_data  output  32  extended load result; valid with done, held until next done.
- err  output  2  00 ok, 01 misaligned, 10 illegal, 11 timeout; valid with done.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_be  output  4  byte enables.
- mem_ready  input  1  memory accepted/completed the request this cycle.
- mem_rdata  input  32  read word; valid when mem_ready=1.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, timeout counter 0.
  - All outputs 0: busy, done, load_data, err, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
- Reset mid-transaction: mem_req drops immediately, no done is produced, the in-flight operation is lost.
- FSM states: IDLE, REQ.
- IDLE:
  - start with is_load=is_store=0: ignored.
  - start with both flags set, or a store with funct3 in {011,100,101,110,111}, or a load with funct3 in {011,110,111}: next cycle done=1, err=10, load_data=0. No mem access, stay IDLE.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): next cycle done=1, err=01, load_data=0. No mem access.
  - Otherwise: register mem_addr, mem_we, mem_be and mem_wdata, assert mem_req, go to REQ, busy=1.
- REQ:
  - mem_req, mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready is sampled high.
  - On mem_ready: drop mem_req, busy=0, done=1 next cycle, err=00, go to IDLE. For loads, load_data is the extracted value; for stores, load_data=0.
  - Counter increments each REQ cycle without mem_ready. When it reaches TIMEOUT: drop mem_req, done=1, err=11, load_data=0, go to IDLE.
- Latency:
  - start sampled at edge T, mem_req high after T.
  - mem_ready high at edge T+1 gives done high after T+1.
  - Minimum latency 2 cycles; error completions take 1 cycle.
- Back-to-back: busy=0 in the done cycle, so a start in that cycle is accepted.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = 0011 or 1100 by addr[1], wdata = {2{sd[15:0]}}.
  - SW: be = 1111, wdata = sd.
- Loads:
  - mem_be = 1111.
  - Byte/halfword selected by addr[1:0]/addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Outside REQ:
  - mem_ready is ignored.
  - start while busy=1 is ignored.
- done is never high for two consecutive cycles from a single start.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B/H/W/BU/HU.
  - err codes ERR_OK/MISALIGN/ILLEGAL/TIMEOUT.
  - state encoding S_IDLE/S_REQ.
- Sub-module lsu_align (combinational):
  - Store path: funct3, addr[1:0], store_data -> mem_be, mem_wdata.
  - Load path: funct3, addr[1:0], mem_rdata -> load_data.
  - Misaligned/illegal flag.
- Top-level holds the FSM, counter and registers.

Test Plan:
- SW addr=0x100, sd=0xDEADBEEF, mem_ready 1 cycle after req -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, mem_we=1; done 2 cycles after start, err=00.
- LB addr=0x203, rdata=0x80FF_FF7F -> be=1111, load_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr=0x102, sd=0x1234ABCD -> be=1100, wdata=0xABCDABCD. LH addr=0x101 -> no mem_req, done next cycle, err=01, load_data=0.
- LW with mem_ready held 0, TIMEOUT=4 -> mem_req high exactly 4 cycles, then done with err=11. Next start is accepted in the done cycle.
- start with is_load=is_store=1 -> done, err=10, no mem_req. Store funct3=100 -> err=10.
- Assert rst_n=0 while in REQ -> mem_req=0 immediately; after release, no done pulse; the next LW completes normally.
